// File: rtl/ddr_rd_dma_if.sv
// Descriptor, AXIS read-data and AXI4 read-channel bundle for ddr_rd_dma.
// master: the DMA engine's view; slave: the core/interconnect side.
interface ddr_rd_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 20
);
  logic [ADDR_WIDTH-1:0] dma_rd_desc_addr;
  logic [LEN_WIDTH-1:0]  dma_rd_desc_len;
  logic                  dma_rd_desc_valid;
  logic                  dma_rd_desc_ready;

  logic [DATA_WIDTH-1:0] dma_rd_read_data_tdata;
  logic                  dma_rd_read_data_tvalid;
  logic                  dma_rd_read_data_tlast;
  logic                  dma_rd_read_data_tready;

  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid, dma_rd_read_data_tready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output dma_rd_desc_ready, dma_rd_read_data_tdata, dma_rd_read_data_tvalid,
           dma_rd_read_data_tlast, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid, dma_rd_read_data_tready,
           m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  dma_rd_desc_ready, dma_rd_read_data_tdata, dma_rd_read_data_tvalid,
           dma_rd_read_data_tlast, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/ddr_rd_dma.sv
// Read DMA: one {addr,len} descriptor -> 4KB-safe AXI4 INCR bursts -> AXIS; rresp/rlast checks under DDR_RD_DMA_ERR_CHK_EN.
// Latency: R beat to AXIS tvalid 1 cycle, 1 beat/clk sustained.
// Backpressure: 2-entry skid drops rready when full; AR stalls at MAX_OUTSTANDING bursts in flight.
module ddr_rd_dma #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int LEN_WIDTH       = 20,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  ddr_rd_dma_if.master bus,
  output logic         busy,
  output logic         err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  beats_left, total_beats, beat_cnt, desc_beats;
  logic [OW-1:0]         outstanding, outstanding_nxt;
  logic                  arvalid_q, desc_ready_q;
  logic [12:0]           page_beats, burst_cap, burst;
  logic                  desc_hs, ar_hs, r_hs, rlast_hs, t_hs, t_last;

  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  skid_wr, skid_rd;
  logic [1:0]            skid_cnt;

  // A burst never runs past the end of the current 4KB page.
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SHIFT;
  assign burst_cap  = (page_beats < 13'(MAX_BURST)) ? page_beats : 13'(MAX_BURST);
  assign burst      = (beats_left < LEN_WIDTH'(burst_cap)) ? beats_left[12:0] : burst_cap;
  assign desc_beats = bus.dma_rd_desc_len >> SHIFT;

  assign desc_hs         = bus.dma_rd_desc_valid && desc_ready_q;
  assign ar_hs           = arvalid_q && bus.m_axi_arready;
  assign r_hs            = bus.m_axi_rvalid && bus.m_axi_rready;
  assign rlast_hs        = r_hs && bus.m_axi_rlast;
  assign t_hs            = (skid_cnt != 2'd0) && bus.dma_rd_read_data_tready;
  assign t_last          = (skid_cnt != 2'd0) && (beat_cnt + LEN_WIDTH'(1) == total_beats);
  assign outstanding_nxt = outstanding + OW'(ar_hs) - OW'(rlast_hs);

  assign bus.dma_rd_desc_ready       = desc_ready_q;
  assign bus.m_axi_araddr            = addr_q;
  assign bus.m_axi_arlen             = 8'(burst - 13'd1);
  assign bus.m_axi_arsize            = 3'(SHIFT);
  assign bus.m_axi_arburst           = 2'b01;
  assign bus.m_axi_arvalid           = arvalid_q;
  assign bus.m_axi_rready            = (state != IDLE) && (skid_cnt != 2'd2);
  assign bus.dma_rd_read_data_tvalid = skid_cnt != 2'd0;
  assign bus.dma_rd_read_data_tdata  = skid_mem[skid_rd];
  assign bus.dma_rd_read_data_tlast  = t_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      beats_left   <= '0;
      total_beats  <= '0;
      beat_cnt     <= '0;
      outstanding  <= '0;
      arvalid_q    <= 1'b0;
      desc_ready_q <= 1'b1;
      busy         <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (t_hs) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      case (state)
        IDLE: begin
          if (desc_hs && desc_beats != '0) begin
            addr_q       <= bus.dma_rd_desc_addr;
            beats_left   <= desc_beats;
            total_beats  <= desc_beats;
            beat_cnt     <= '0;
            arvalid_q    <= 1'b1;
            desc_ready_q <= 1'b0;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            addr_q     <= addr_q + (ADDR_WIDTH'(burst) << SHIFT);
            beats_left <= beats_left - LEN_WIDTH'(burst);
          end
          if (ar_hs && beats_left == LEN_WIDTH'(burst)) begin
            arvalid_q <= 1'b0;
            state     <= DRAIN;
          end else if (!arvalid_q || ar_hs) begin
            // arvalid only rises with a free outstanding slot, so it never needs retracting.
            arvalid_q <= outstanding_nxt < OW'(MAX_OUTSTANDING);
          end
        end
        DRAIN: begin
          if (t_hs && t_last) begin
            state        <= IDLE;
            busy         <= 1'b0;
            desc_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_wr  <= 1'b0;
      skid_rd  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (r_hs) skid_wr <= ~skid_wr;
      if (t_hs) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + 2'(r_hs) - 2'(t_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) skid_mem[skid_wr] <= bus.m_axi_rdata;
  end

`ifdef DDR_RD_DMA_ERR_CHK_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic [7:0]    len_fifo [2**PW];
  logic [PW-1:0] lf_wr, lf_rd;
  logic [8:0]    rbeat;

  // arlen of each in-flight burst, popped on its rlast to validate beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lf_wr <= '0;
      lf_rd <= '0;
      rbeat <= '0;
      err   <= 1'b0;
    end else begin
      if (ar_hs) begin
        len_fifo[lf_wr] <= bus.m_axi_arlen;
        lf_wr           <= lf_wr + 1'b1;
      end
      if (r_hs) begin
        if (bus.m_axi_rresp != 2'b00) err <= 1'b1;
        if (bus.m_axi_rlast) begin
          if (rbeat != {1'b0, len_fifo[lf_rd]}) err <= 1'b1;
          lf_rd <= lf_rd + 1'b1;
          rbeat <= '0;
        end else begin
          rbeat <= rbeat + 9'd1;
        end
      end
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^bus.m_axi_rresp;
  assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_rd_dma.sv
// Directed bench for ddr_rd_dma: table of descriptors against a small AXI read slave model,
// plus hand-written reset-state, mid-burst reset and recovery sequences.
module tb_ddr_rd_dma;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int LW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  always #5 clk = ~clk;

  ddr_rd_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ddr_rd_dma #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err)
  );

  typedef struct {
    int addr; int len; int tmode; int err_beat; int abort;
    int n_ar; int ar0_addr; int ar0_len; int ar1_addr; int ar1_len;
    int beats; int max_infl; int rready_low; int span;
  } vec_t;

  typedef struct { int addr; int beats; } ar_t;

  int   checks = 0;
  int   errors = 0;
  ar_t  arq[$];
  int   r_idx = 0;
  int   r_total = 0;
  int   err_exp = 0;
  vec_t vt[8];
  vec_t v_abort, v_recover;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_idle();
    bus.dma_rd_desc_valid       = 1'b0;
    bus.dma_rd_desc_addr        = '0;
    bus.dma_rd_desc_len         = '0;
    bus.dma_rd_read_data_tready = 1'b0;
    bus.m_axi_arready           = 1'b0;
    bus.m_axi_rvalid            = 1'b0;
    bus.m_axi_rlast             = 1'b0;
    bus.m_axi_rresp             = 2'b00;
    bus.m_axi_rdata             = '0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int n_ar = 0, beats = 0, infl = 0, max_infl = 0, bad_data = 0, bad_ar = 0, hold_bad = 0;
    int tlast_cnt = 0, tlast_pos = -1, rready_low = 0, busy_seen = 0, dr_low = 0, err_bad = 0;
    int first_t = -1, last_t = -1, cyc = 0, post = -1;
    int ar_addr[$];
    int ar_len[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] prev_data = '0;
    bit prev_stall = 0, prev_last = 0, done = 0;
    r_total = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.dma_rd_desc_valid = 1'b1;
        bus.dma_rd_desc_addr  = AW'(v.addr);
        bus.dma_rd_desc_len   = LW'(v.len);
      end else if (v.len != 0 && post < 0) begin
        // a second descriptor held during the transfer must be ignored
        bus.dma_rd_desc_valid = 1'b1;
        bus.dma_rd_desc_addr  = 32'h000D_E000;
        bus.dma_rd_desc_len   = LW'(64);
      end else begin
        bus.dma_rd_desc_valid = 1'b0;
      end
      if (v.tmode == 0)      bus.dma_rd_read_data_tready = 1'b1;
      else if (v.tmode == 1) bus.dma_rd_read_data_tready = (cyc % 3 == 0);
      else                   bus.dma_rd_read_data_tready = 1'b0;
      bus.m_axi_arready = 1'b1;
      if (arq.size() > 0) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = {8{64'(arq[0].addr + r_idx * 64)}};
        bus.m_axi_rlast  = (r_idx == arq[0].beats - 1);
        bus.m_axi_rresp  = (r_total == v.err_beat) ? 2'b10 : 2'b00;
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
      end
      #1;
      if (err !== (err_exp != 0)) err_bad++;
      if (post >= 0) begin
        chk($sformatf("v%0d busy_low_after_last", id), busy, 0);
        chk($sformatf("v%0d desc_ready_after_last", id), bus.dma_rd_desc_ready, 1);
        done = 1;
      end else begin
        if (busy) busy_seen = 1;
        if (!bus.dma_rd_desc_ready) dr_low = 1;
        if (busy && !bus.m_axi_rready) rready_low = 1;
        if (prev_stall && (!bus.dma_rd_read_data_tvalid || bus.dma_rd_read_data_tdata != prev_data
                           || bus.dma_rd_read_data_tlast != prev_last)) hold_bad++;
        prev_stall = bus.dma_rd_read_data_tvalid && !bus.dma_rd_read_data_tready;
        prev_data  = bus.dma_rd_read_data_tdata;
        prev_last  = bus.dma_rd_read_data_tlast;
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          r_total++;
          if (bus.m_axi_rlast) begin
            infl--;
            void'(arq.pop_front());
            r_idx = 0;
          end else begin
            r_idx++;
          end
`ifdef DDR_RD_DMA_ERR_CHK_EN
          if (bus.m_axi_rresp != 2'b00) err_exp = 1;
`endif
        end
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          n_ar++;
          ar_addr.push_back(int'(bus.m_axi_araddr));
          ar_len.push_back(int'(bus.m_axi_arlen));
          if (bus.m_axi_arsize != 3'd6 || bus.m_axi_arburst != 2'b01 ||
              (int'(bus.m_axi_araddr) % 4096) + (int'(bus.m_axi_arlen) + 1) * 64 > 4096) bad_ar++;
          arq.push_back('{int'(bus.m_axi_araddr), int'(bus.m_axi_arlen) + 1});
          infl++;
          if (infl > max_infl) max_infl = infl;
        end
        if (bus.dma_rd_read_data_tvalid && bus.dma_rd_read_data_tready) begin
          exp_d = {8{64'(v.addr + beats * 64)}};
          if (bus.dma_rd_read_data_tdata != exp_d) bad_data++;
          if (bus.dma_rd_read_data_tlast) begin
            tlast_cnt++;
            tlast_pos = beats + 1;
            post = cyc;
          end
          if (first_t < 0) first_t = cyc;
          last_t = cyc;
          beats++;
        end
        if (v.len == 0 && cyc == 20) done = 1;
        if (cyc == v.abort) begin
          chk($sformatf("v%0d midburst_busy", id), busy, 1);
          chk($sformatf("v%0d midburst_tvalid", id), bus.dma_rd_read_data_tvalid, 1);
          chk($sformatf("v%0d midburst_rready_full", id), bus.m_axi_rready, 0);
          return;
        end
      end
      cyc++;
    end
    chk($sformatf("v%0d completed_in_budget", id), done, 1);
    chk($sformatf("v%0d ar_count", id), n_ar, v.n_ar);
    if (v.n_ar >= 1 && n_ar >= 1) begin
      chk($sformatf("v%0d ar0_addr", id), ar_addr[0], v.ar0_addr);
      chk($sformatf("v%0d ar0_len", id), ar_len[0], v.ar0_len);
    end
    if (v.n_ar >= 2 && n_ar >= 2) begin
      chk($sformatf("v%0d ar1_addr", id), ar_addr[1], v.ar1_addr);
      chk($sformatf("v%0d ar1_len", id), ar_len[1], v.ar1_len);
    end
    chk($sformatf("v%0d beats", id), beats, v.beats);
    chk($sformatf("v%0d bad_data_beats", id), bad_data, 0);
    chk($sformatf("v%0d bad_ar_attrs", id), bad_ar, 0);
    chk($sformatf("v%0d unstable_while_stalled", id), hold_bad, 0);
    chk($sformatf("v%0d tlast_count", id), tlast_cnt, (v.beats > 0) ? 1 : 0);
    chk($sformatf("v%0d tlast_pos", id), tlast_pos, (v.beats > 0) ? v.beats : -1);
    chk($sformatf("v%0d max_outstanding", id), max_infl, v.max_infl);
    chk($sformatf("v%0d rready_dropped", id), rready_low, v.rready_low);
    chk($sformatf("v%0d busy_seen", id), busy_seen, (v.len != 0) ? 1 : 0);
    chk($sformatf("v%0d desc_ready_dropped", id), dr_low, (v.len != 0) ? 1 : 0);
    chk($sformatf("v%0d err_track_mismatches", id), err_bad, 0);
    if (v.span >= 0) chk($sformatf("v%0d stream_span", id), last_t - first_t, v.span);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
    chk({tag, "_rready"}, bus.m_axi_rready, 0);
    chk({tag, "_tvalid"}, bus.dma_rd_read_data_tvalid, 0);
    chk({tag, "_tlast"}, bus.dma_rd_read_data_tlast, 0);
    chk({tag, "_desc_ready"}, bus.dma_rd_desc_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    //        addr     len  tm  eb  ab  nar ar0a    a0l ar1a    a1l beats inf rl span
    vt[0] = '{'h1000, 4096,  0, -1, -1, 1, 'h1000, 63, 0,      0,  64,   1,  0, 63};
    vt[1] = '{'h0F80, 512,   0, -1, -1, 2, 'h0F80, 1,  'h1000, 5,  8,    2,  0, 7};
    vt[2] = '{'h0800, 16384, 0, -1, -1, 5, 'h0800, 31, 'h1000, 63, 256,  4,  0, 255};
    vt[3] = '{'h0000, 4096,  1, -1, -1, 1, 'h0000, 63, 0,      0,  64,   1,  1, -1};
    vt[4] = '{'h2000, 0,     0, -1, -1, 0, 0,      0,  0,      0,  0,    0,  0, -1};
    vt[5] = '{'h3FC0, 128,   0, -1, -1, 2, 'h3FC0, 0,  'h4000, 0,  2,    1,  0, 1};
    vt[6] = '{'h5000, 64,    0, -1, -1, 1, 'h5000, 0,  0,      0,  1,    1,  0, 0};
    vt[7] = '{'h6000, 512,   0,  4, -1, 1, 'h6000, 7,  0,      0,  8,    1,  0, 7};
    v_abort   = '{'h0000, 4096, 2, -1, 8, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    v_recover = '{'h7000, 256,  0, -1, -1, 1, 'h7000, 3, 0, 0, 4, 1, 0, 3};

    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // reset while the skid is full and a burst is still in flight
    run_vec(8, v_abort);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    arq.delete();
    r_idx   = 0;
    err_exp = 0;
    @(negedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;

    run_vec(9, v_recover);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
